// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: one shared prescaler divides clk down to a base
// tick, and each channel counts base ticks down to a one-cycle expiry pulse.
// Expiries are collected into sticky write-1-to-clear interrupt flags.
//
// Channel states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | channel stopped, counter ignored, prescaler not requested
//   ST_RUN  | channel counting base ticks, pulses when the count expires
module tick_scheduler #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic                wr_oneshot,
    input  logic [NUM_CH-1:0]   start,
    input  logic [NUM_CH-1:0]   stop,
    input  logic [NUM_CH-1:0]   irq_clr,
    output logic                tick_out,
    output logic [NUM_CH-1:0]   ch_pulse,
    output logic [NUM_CH-1:0]   ch_active,
    output logic [NUM_CH-1:0]   irq_status,
    output logic                irq
);

    localparam int DIV  = CLK_FREQ / TICK_HZ;
    localparam int PC_W = $clog2(DIV);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q    [NUM_CH];
    state_e              state_d    [NUM_CH];
    logic [PERIOD_W-1:0] cnt_q      [NUM_CH];
    logic [PERIOD_W-1:0] cnt_d      [NUM_CH];
    logic [PERIOD_W-1:0] period_q   [NUM_CH];
    logic [PERIOD_W-1:0] eff_period [NUM_CH];
    logic [NUM_CH-1:0]   oneshot_q;
    logic [NUM_CH-1:0]   run_vec;
    logic [NUM_CH-1:0]   pulse_d;
    logic [NUM_CH-1:0]   pulse_q;
    logic [NUM_CH-1:0]   irq_status_d;
    logic [NUM_CH-1:0]   irq_status_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic                runs;
    logic                tick;

    // Period seen by a start: a write to the same channel in the same cycle wins.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eff_period[i] = period_q[i];
            if (wr_en && (wr_ch == CH_W'(i))) begin
                eff_period[i] = wr_period;
            end
            run_vec[i] = (state_q[i] == ST_RUN);
        end
    end

    assign runs = |run_vec;
    assign tick = runs && (pc_q == PC_LAST);

    // Prescaler next value: free-runs only while some channel needs it.
    always_comb begin
        pc_d = '0;
        if (runs) begin
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
        end
    end

    // Channel next-state: stop beats start, start beats a coincident tick.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (start[i] && !stop[i] && (eff_period[i] != '0)) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = eff_period[i];
                    end
                end
                ST_RUN: begin
                    if (stop[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (start[i]) begin
                        // A restart with a zero period has nothing to count.
                        if (eff_period[i] != '0) begin
                            cnt_d[i] = eff_period[i];
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else if (tick) begin
                        if (cnt_q[i] == PERIOD_W'(1)) begin
                            pulse_d[i] = 1'b1;
                            // Reload uses the stored period; zero means stop.
                            if (oneshot_q[i] || (period_q[i] == '0)) begin
                                state_d[i] = ST_IDLE;
                            end else begin
                                cnt_d[i] = period_q[i];
                            end
                        end else if (cnt_q[i] > PERIOD_W'(1)) begin
                            cnt_d[i] = cnt_q[i] - PERIOD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a new expiry outranks a same-cycle clear.
    always_comb begin
        irq_status_d = (irq_status_q & ~irq_clr) | pulse_d;
    end

    // Channel state, counters, pulses, flags and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pulse_q      <= '0;
            irq_status_q <= '0;
            pc_q         <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pulse_q      <= pulse_d;
            irq_status_q <= irq_status_d;
            pc_q         <= pc_d;
        end
    end

    // Configuration registers: period and mode per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
            end
            oneshot_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) begin
                    period_q[i]  <= wr_period;
                    oneshot_q[i] <= wr_oneshot;
                end
            end
        end
    end

    assign tick_out   = tick;
    assign ch_pulse   = pulse_q;
    assign ch_active  = run_vec;
    assign irq_status = irq_status_q;
    assign irq        = |irq_status_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (DIV=8, 4 channels, 8-bit periods). The reference
// model tracks each channel as an absolute deadline (edge number of its next
// pulse) derived from the prescaler origin, rather than as a tick counter.
module tb_tick_scheduler;

    localparam int DIV = 8;
    localparam int NCH = 4;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_period;
    logic       wr_oneshot;
    logic [3:0] start;
    logic [3:0] stop;
    logic [3:0] irq_clr;
    logic       tick_out;
    logic [3:0] ch_pulse;
    logic [3:0] ch_active;
    logic [3:0] irq_status;
    logic       irq;

    tick_scheduler #(
        .CLK_FREQ(8),
        .TICK_HZ (1),
        .NUM_CH  (4),
        .PERIOD_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_period (wr_period),
        .wr_oneshot(wr_oneshot),
        .start     (start),
        .stop      (stop),
        .irq_clr   (irq_clr),
        .tick_out  (tick_out),
        .ch_pulse  (ch_pulse),
        .ch_active (ch_active),
        .irq_status(irq_status),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    int         m_cyc;
    int         m_org;
    logic [3:0] m_act;
    int         m_dl  [NCH];
    int         m_per [NCH];
    logic [3:0] m_os;
    logic [3:0] m_pulse;
    logic [3:0] m_irq;
    logic       m_tick;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, m_cyc, act, exp);
        end
    endtask

    // Edge number of the pulse for a count of p ticks starting at edge n:
    // the first tick cycle at or after n, plus p-1 further ticks, plus one edge.
    function automatic int deadline(input int n, input int p);
        int c;
        c = m_org + DIV - 1;
        if (n > c) c = c + ((n - c + DIV - 1) / DIV) * DIV;
        return c + DIV * (p - 1) + 1;
    endfunction

    task automatic model_reset();
        m_act   = '0;
        m_os    = '0;
        m_pulse = '0;
        m_irq   = '0;
        m_tick  = 1'b0;
        m_org   = m_cyc;
        for (int i = 0; i < NCH; i++) begin
            m_dl[i]  = 0;
            m_per[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] pul;
        int         effp;
        pul = '0;
        if (m_act == '0) m_org = m_cyc;
        for (int i = 0; i < NCH; i++) begin
            effp = (wr_en && int'(wr_ch) == i) ? int'(wr_period) : m_per[i];
            if (!m_act[i]) begin
                if (start[i] && !stop[i] && effp != 0) begin
                    m_act[i] = 1'b1;
                    m_dl[i]  = deadline(m_cyc, effp);
                end
            end else if (stop[i]) begin
                m_act[i] = 1'b0;
            end else if (start[i]) begin
                if (effp != 0) m_dl[i] = deadline(m_cyc, effp);
                else m_act[i] = 1'b0;
            end else if (m_dl[i] == m_cyc) begin
                pul[i] = 1'b1;
                if (m_os[i] || m_per[i] == 0) m_act[i] = 1'b0;
                else m_dl[i] = deadline(m_cyc, m_per[i]);
            end
        end
        if (wr_en) begin
            m_per[wr_ch] = int'(wr_period);
            m_os[wr_ch]  = wr_oneshot;
        end
        m_irq   = (m_irq & ~irq_clr) | pul;
        m_pulse = pul;
        m_tick  = (m_act != '0) && ((m_cyc - m_org) % DIV == DIV - 1);
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_cyc++;
                model_step();
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("tick_out", tick_out, m_tick);
                chk("ch_pulse", ch_pulse, m_pulse);
                chk("ch_active", ch_active, m_act);
                chk("irq_status", irq_status, m_irq);
                chk("irq", irq, |m_irq);
            end
        end
    end

    task automatic idle_inputs();
        wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_oneshot = 1'b0;
        start = '0; stop = '0; irq_clr = '0;
    endtask

    task automatic do_write(input int ch, input int p, input logic os);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_period = 8'(p); wr_oneshot = os;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_start(input logic [3:0] m, output int e);
        start = m;
        @(negedge clk);
        e = m_cyc;
        idle_inputs();
    endtask

    task automatic do_stop(input logic [3:0] m);
        stop = m;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_clr(input logic [3:0] m);
        irq_clr = m;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_to(input int t);
        while (m_cyc < t) @(negedge clk);
    endtask

    task automatic quiesce();
        do_stop(4'hF);
        do_clr(4'hF);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s;
        int e;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", tick_out, 1'b0);
        chk("rst_pulse", ch_pulse, 4'h0);
        chk("rst_active", ch_active, 4'h0);
        chk("rst_irq", {irq_status, irq}, 5'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset while running
        wr_en = 1'b1; wr_ch = 2'd0; wr_period = 8'd3; wr_oneshot = 1'b0;
        do_start(4'b0001, s);
        wait_to(s + 10);
        chk("t1_active_pre", ch_active, 4'b0001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_active", ch_active, 4'h0);
        chk("t1_rst_tick", tick_out, 1'b0);
        chk("t1_rst_pulse", ch_pulse, 4'h0);
        chk("t1_rst_irq", irq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t1_after_active", ch_active, 4'h0);
        chk("t1_after_irq", irq, 1'b0);

        // 2: periodic timing, irq set/clear
        do_write(0, 3, 1'b0);
        do_start(4'b0001, s);
        wait_to(s + 6);  chk("t2_tick6", tick_out, 1'b0);
        wait_to(s + 7);  chk("t2_tick7", tick_out, 1'b1);
        wait_to(s + 15); chk("t2_tick15", tick_out, 1'b1);
        wait_to(s + 23); chk("t2_pulse23", ch_pulse, 4'h0);
        wait_to(s + 24); chk("t2_pulse24", ch_pulse, 4'b0001);
        chk("t2_irq24", irq, 1'b1);
        wait_to(s + 25); chk("t2_pulse25", ch_pulse, 4'h0);
        wait_to(s + 29); do_clr(4'b0001);
        chk("t2_irq30", irq, 1'b0);
        wait_to(s + 47); chk("t2_irq47", irq, 1'b0);
        wait_to(s + 48); chk("t2_pulse48", ch_pulse, 4'b0001);
        chk("t2_irq48", irq, 1'b1);
        wait_to(s + 72); chk("t2_pulse72", ch_pulse, 4'b0001);
        quiesce();

        // 3: one-shot
        do_write(1, 2, 1'b1);
        do_start(4'b0010, s);
        wait_to(s + 15); chk("t3_pulse15", ch_pulse, 4'h0);
        wait_to(s + 16); chk("t3_pulse16", ch_pulse, 4'b0010);
        chk("t3_active16", ch_active, 4'h0);
        wait_to(s + 23); chk("t3_tick23", tick_out, 1'b0);
        wait_to(s + 40); chk("t3_pulse40", ch_pulse, 4'h0);
        quiesce();

        // 4: conflicts
        do_write(2, 2, 1'b0);
        start = 4'b0100; stop = 4'b0100;
        @(negedge clk); idle_inputs();
        chk("t4_startstop", ch_active, 4'h0);
        do_start(4'b1000, e);
        chk("t4_period0", ch_active, 4'h0);
        do_start(4'b0100, s);
        wait_to(s + 15); do_stop(4'b0100);
        chk("t4_stop_expiry_pulse", ch_pulse, 4'h0);
        chk("t4_stop_expiry_active", ch_active, 4'h0);
        do_start(4'b0100, s);
        wait_to(s + 15); do_clr(4'b0100);
        chk("t4_clr_pulse", ch_pulse, 4'b0100);
        chk("t4_clr_irq", irq_status, 4'b0100);
        quiesce();

        // 5: live reconfiguration and restart
        do_write(0, 3, 1'b0);
        do_start(4'b0001, s);
        wait_to(s + 9); do_write(0, 5, 1'b0);
        wait_to(s + 24); chk("t5_pulse24", ch_pulse, 4'b0001);
        wait_to(s + 63); chk("t5_pulse63", ch_pulse, 4'h0);
        wait_to(s + 64); chk("t5_pulse64", ch_pulse, 4'b0001);
        wait_to(s + 69); do_start(4'b0001, e);
        wait_to(s + 104); chk("t5_pulse104", ch_pulse, 4'b0001);
        wait_to(s + 120);
        quiesce();

        // 6: shared prescaler phase
        do_write(0, 4, 1'b0);
        do_write(3, 1, 1'b0);
        do_start(4'b0001, s);
        wait_to(s + 4); do_start(4'b1000, e);
        wait_to(s + 7);  chk("t6_pulse7", ch_pulse, 4'h0);
        wait_to(s + 8);  chk("t6_pulse8", ch_pulse, 4'b1000);
        wait_to(s + 16); chk("t6_pulse16", ch_pulse, 4'b1000);
        wait_to(s + 32); chk("t6_pulse32", ch_pulse, 4'b1001);
        quiesce();

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            wr_en      = ($urandom % 8 == 0);
            wr_ch      = 2'($urandom % 4);
            wr_period  = ($urandom % 10 == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            wr_oneshot = ($urandom % 3 == 0);
            for (int b = 0; b < NCH; b++) begin
                start[b]   = ($urandom % 20 == 0);
                stop[b]    = ($urandom % 40 == 0);
                irq_clr[b] = ($urandom % 8 == 0);
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (50) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
